// File: rtl/system_rst_seq_if.sv
// Reset-sequencer signal bundle: button/soft reset requests, PLL handshake
// and the staged per-domain reset outputs.
interface system_rst_seq_if #(
  parameter int unsigned NUM_DOMAINS = 3
);
  logic                   ext_rst_n;
  logic                   soft_rst;
  logic                   pll_locked;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] dom_rst_n;
  logic                   sys_ready;
  logic [7:0]             lock_loss_cnt;

  modport master (
    input  ext_rst_n, soft_rst, pll_locked,
    output pll_rst, dom_rst_n, sys_ready, lock_loss_cnt
  );

  modport slave (
    output ext_rst_n, soft_rst, pll_locked,
    input  pll_rst, dom_rst_n, sys_ready, lock_loss_cnt
  );
endinterface

// File: rtl/system_rst_seq.sv
// PLL reset / lock-filter / staged domain-release sequencer with lock-loss,
// button-reset and soft-reset handling and a saturating lock-loss counter.
module system_rst_seq #(
  parameter int unsigned NUM_DOMAINS    = 3,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_FILTER    = 1024,
  parameter int unsigned STAGE_DELAY    = 256
) (
  input  logic             clk,
  input  logic             rst,
  system_rst_seq_if.master bus
);

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_FILTER    = 3'd2;
  localparam logic [2:0] ST_RELEASE   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_SOFT_HOLD = 3'd5;

  localparam int unsigned HOLD_LEN = 2 * STAGE_DELAY;
  localparam int unsigned CNT_A    = (PLL_RST_CYCLES > LOCK_FILTER) ? PLL_RST_CYCLES : LOCK_FILTER;
  localparam int unsigned CNT_MAX  = (CNT_A > HOLD_LEN) ? CNT_A : HOLD_LEN;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam int unsigned IW       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CW-1:0] PLL_END   = CW'(PLL_RST_CYCLES);
  localparam logic [CW-1:0] FILT_END  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] STAGE_END = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(HOLD_LEN - 1);
  localparam logic [IW-1:0] LAST_DOM  = IW'(NUM_DOMAINS - 1);

  logic [2:0]             state;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   ext_s1;
  logic                   ext_s2;
  logic                   pll_rst_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic                   ready_q;
  logic [7:0]             loss_q;
  logic                   armed;
  logic                   lock_lost;
  logic                   to_pll;

  assign armed     = (state == ST_RELEASE) || (state == ST_RUN) || (state == ST_SOFT_HOLD);
  assign lock_lost = armed && !bus.pll_locked;
  assign to_pll    = !ext_s2 || lock_lost;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PLL_RST;
      cnt       <= '0;
      idx       <= '0;
      ext_s1    <= 1'b1;
      ext_s2    <= 1'b1;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      loss_q    <= '0;
    end else begin
      ext_s1 <= bus.ext_rst_n;
      ext_s2 <= ext_s1;
      if (to_pll) begin
        state     <= ST_PLL_RST;
        cnt       <= '0;
        idx       <= '0;
        pll_rst_q <= 1'b1;
        dom_q     <= '0;
        ready_q   <= 1'b0;
        // A button reset on the same edge masks the lock-loss count.
        if (ext_s2 && (loss_q != 8'hFF)) loss_q <= loss_q + 8'd1;
      end else begin
        case (state)
          ST_PLL_RST: begin
            if (cnt == PLL_END) begin
              state     <= ST_WAIT_LOCK;
              cnt       <= '0;
              pll_rst_q <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (bus.pll_locked) begin
              state <= ST_FILTER;
              cnt   <= '0;
            end
          end
          ST_FILTER: begin
            if (!bus.pll_locked) begin
              state <= ST_WAIT_LOCK;
            end else if (cnt == FILT_END) begin
              state    <= ST_RELEASE;
              cnt      <= '0;
              idx      <= '0;
              dom_q[0] <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RELEASE: begin
            if (idx == LAST_DOM) begin
              state   <= ST_RUN;
              ready_q <= 1'b1;
            end else if (cnt == STAGE_END) begin
              cnt                <= '0;
              idx                <= idx + 1'b1;
              dom_q[idx + 1'b1]  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RUN: begin
            if (bus.soft_rst) begin
              state   <= ST_SOFT_HOLD;
              cnt     <= '0;
              dom_q   <= '0;
              ready_q <= 1'b0;
            end
          end
          ST_SOFT_HOLD: begin
            // Hold time plus one stage spacing before domain 0 comes back.
            if (cnt == HOLD_END) begin
              state    <= ST_RELEASE;
              cnt      <= '0;
              idx      <= '0;
              dom_q[0] <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state     <= ST_PLL_RST;
            cnt       <= '0;
            idx       <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.dom_rst_n     = dom_q;
  assign bus.sys_ready     = ready_q;
  assign bus.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_system_rst_seq.sv
// Bench for system_rst_seq: directed timing steps plus random traffic, all
// outputs compared each cycle with a phase/elapsed-time reference model.
module tb_system_rst_seq;

  localparam int N = 3;
  localparam int P = 4;
  localparam int L = 8;
  localparam int S = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  system_rst_seq_if #(.NUM_DOMAINS(N)) bus ();

  system_rst_seq #(
    .NUM_DOMAINS   (N),
    .PLL_RST_CYCLES(P),
    .LOCK_FILTER   (L),
    .STAGE_DELAY   (S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Reference model: current phase, edges elapsed since entering it, loss total.
  typedef enum int {PH_PLL, PH_WAIT, PH_FILT, PH_REL, PH_RUN, PH_HOLD} ph_t;
  ph_t      ph     = PH_PLL;
  int       age    = 0;
  int       losses = 0;
  int       m_edge = -1;
  bit [1:0] ext_pipe = 2'b11;

  task automatic enter(input ph_t p);
    ph  = p;
    age = 0;
  endtask

  always @(posedge clk) begin
    bit s2;
    int a;
    if (rst) begin
      enter(PH_PLL);
      losses   = 0;
      ext_pipe = 2'b11;
      m_edge   = -1;
    end else begin
      s2       = ext_pipe[1];
      ext_pipe = {ext_pipe[0], bus.ext_rst_n};
      m_edge++;
      a = age + 1;
      if (!s2) begin
        enter(PH_PLL);
      end else if (!bus.pll_locked && (ph == PH_REL || ph == PH_RUN || ph == PH_HOLD)) begin
        if (losses < 255) losses++;
        enter(PH_PLL);
      end else begin
        case (ph)
          PH_PLL:  if (a == P + 1) enter(PH_WAIT); else age = a;
          PH_WAIT: if (bus.pll_locked) enter(PH_FILT); else age = a;
          PH_FILT: if (!bus.pll_locked) enter(PH_WAIT);
                   else if (a == L) enter(PH_REL); else age = a;
          PH_REL:  if (a == (N - 1) * S + 1) enter(PH_RUN); else age = a;
          PH_RUN:  if (bus.soft_rst) enter(PH_HOLD); else age = a;
          PH_HOLD: if (a == 2 * S) enter(PH_REL); else age = a;
          default: enter(PH_PLL);
        endcase
      end
    end
  end

  function automatic int exp_dom();
    int rel;
    if (ph == PH_RUN) return (1 << N) - 1;
    if (ph != PH_REL) return 0;
    rel = age / S + 1;
    if (rel > N) rel = N;
    return (1 << rel) - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("model_pll_rst",   {31'b0, bus.pll_rst},       (ph == PH_PLL) ? 1 : 0);
    chk("model_dom_rst_n", {29'b0, bus.dom_rst_n},     exp_dom());
    chk("model_sys_ready", {31'b0, bus.sys_ready},     (ph == PH_RUN) ? 1 : 0);
    chk("model_loss_cnt",  {24'b0, bus.lock_loss_cnt}, losses);
  endtask

  task automatic run_to(input int k);
    int guard = 0;
    while (m_edge < k && guard < 5000) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    int ext_hold = 0;
    bus.ext_rst_n  = 1'b1;
    bus.soft_rst   = 1'b0;
    bus.pll_locked = 1'b1;
    repeat (3) tick();
    chk("reset_pll_rst",   {31'b0, bus.pll_rst},       1);
    chk("reset_dom",       {29'b0, bus.dom_rst_n},     0);
    chk("reset_ready",     {31'b0, bus.sys_ready},     0);
    chk("reset_loss",      {24'b0, bus.lock_loss_cnt}, 0);
    rst = 1'b0;

    // Bring-up timing
    run_to(3);  chk("pll_rst_E3",  {31'b0, bus.pll_rst},   1);
    run_to(4);  chk("pll_rst_E4",  {31'b0, bus.pll_rst},   0);
    run_to(12); chk("dom_E12",     {29'b0, bus.dom_rst_n}, 0);
    run_to(13); chk("dom_E13",     {29'b0, bus.dom_rst_n}, 1);
    run_to(17); chk("dom_E17",     {29'b0, bus.dom_rst_n}, 1);
    run_to(18); chk("dom_E18",     {29'b0, bus.dom_rst_n}, 3);
    run_to(23); chk("dom_E23",     {29'b0, bus.dom_rst_n}, 7);
                chk("ready_E23",   {31'b0, bus.sys_ready}, 0);
    run_to(24); chk("ready_E24",   {31'b0, bus.sys_ready}, 1);

    // Soft reset pulse sampled at E30
    run_to(29); bus.soft_rst = 1'b1;
    run_to(30); bus.soft_rst = 1'b0;
    chk("soft_dom_E30",   {29'b0, bus.dom_rst_n}, 0);
    chk("soft_ready_E30", {31'b0, bus.sys_ready}, 0);
    chk("soft_pll_E30",   {31'b0, bus.pll_rst},   0);
    run_to(39); chk("soft_dom_E39", {29'b0, bus.dom_rst_n}, 0);
    run_to(40); chk("soft_dom_E40", {29'b0, bus.dom_rst_n}, 1);
    run_to(45); chk("soft_dom_E45", {29'b0, bus.dom_rst_n}, 3);
    run_to(50); chk("soft_dom_E50", {29'b0, bus.dom_rst_n}, 7);
    run_to(51); chk("soft_ready_E51", {31'b0, bus.sys_ready}, 1);

    // Lock loss in RUN sampled at E60
    run_to(59); bus.pll_locked = 1'b0;
    run_to(60); bus.pll_locked = 1'b1;
    chk("loss_dom",   {29'b0, bus.dom_rst_n},     0);
    chk("loss_ready", {31'b0, bus.sys_ready},     0);
    chk("loss_pll",   {31'b0, bus.pll_rst},       1);
    chk("loss_cnt1",  {24'b0, bus.lock_loss_cnt}, 1);
    run_to(74); chk("relock_dom_E74", {29'b0, bus.dom_rst_n}, 1);

    // Button reset mid-RELEASE, lock dropping when the synchronised reset lands
    run_to(75); bus.ext_rst_n = 1'b0;
    run_to(77); chk("ext_dom_E77", {29'b0, bus.dom_rst_n}, 1);
    bus.pll_locked = 1'b0;
    run_to(78);
    chk("ext_dom_E78",  {29'b0, bus.dom_rst_n},     0);
    chk("ext_pll_E78",  {31'b0, bus.pll_rst},       1);
    chk("ext_cnt_E78",  {24'b0, bus.lock_loss_cnt}, 1);
    run_to(80); bus.pll_locked = 1'b1;
    run_to(95); bus.ext_rst_n = 1'b1;
    run_to(101); chk("ext_pll_E101", {31'b0, bus.pll_rst}, 1);
    run_to(102); chk("ext_pll_E102", {31'b0, bus.pll_rst}, 0);
                 chk("ext_cnt_E102", {24'b0, bus.lock_loss_cnt}, 1);
    run_to(110); chk("ext_dom_E110", {29'b0, bus.dom_rst_n}, 0);
    run_to(111); chk("ext_dom_E111", {29'b0, bus.dom_rst_n}, 1);

    // Repeated lock losses in RELEASE until the counter saturates
    repeat (300) begin
      bus.pll_locked = 1'b0;
      tick();
      bus.pll_locked = 1'b1;
      repeat (14) tick();
    end
    chk("loss_saturated", {24'b0, bus.lock_loss_cnt}, 255);

    // Synchronous reset from RUN
    repeat (12) tick();
    chk("pre_rst_ready", {31'b0, bus.sys_ready}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_run_pll",   {31'b0, bus.pll_rst},       1);
    chk("rst_run_dom",   {29'b0, bus.dom_rst_n},     0);
    chk("rst_run_ready", {31'b0, bus.sys_ready},     0);
    chk("rst_run_loss",  {24'b0, bus.lock_loss_cnt}, 0);

    // Soft reset ignored in WAIT_LOCK, then a lock glitch during FILTER
    run_to(4); bus.soft_rst = 1'b1;
    run_to(5); bus.soft_rst = 1'b0;
    run_to(8); bus.pll_locked = 1'b0;
    run_to(9); bus.pll_locked = 1'b1;
    chk("glitch_dom_E9", {29'b0, bus.dom_rst_n}, 0);
    run_to(17); chk("glitch_dom_E17", {29'b0, bus.dom_rst_n}, 0);
    run_to(18); chk("glitch_dom_E18", {29'b0, bus.dom_rst_n}, 1);
                chk("glitch_loss",    {24'b0, bus.lock_loss_cnt}, 0);
    run_to(28); chk("glitch_dom_E28", {29'b0, bus.dom_rst_n}, 7);
    run_to(29); chk("glitch_ready_E29", {31'b0, bus.sys_ready}, 1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.pll_locked = ($urandom_range(0, 99) < 96);
      bus.soft_rst   = ($urandom_range(0, 99) < 3);
      if (ext_hold > 0) begin
        ext_hold--;
        bus.ext_rst_n = 1'b0;
      end else begin
        bus.ext_rst_n = 1'b1;
        if ($urandom_range(0, 99) == 0) ext_hold = $urandom_range(1, 8);
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/system_rst_seq.md
# system_rst_seq

Parametrised reset and clock-bring-up sequencer that drives the PLL reset and releases a configurable number of downstream reset domains in a fixed staged order. The domains are SDRAM controller, CMOS capture and VGA output. The block holds the PLL in reset for a programmable width, then requires `pll_locked` to stay high for a programmable number of consecutive cycles. It then deasserts per-domain resets at programmable spacing. While running it watches for lock loss, external button reset and soft reset, and counts lock-loss events.

## Interface
- `NUM_DOMAINS`, 3: number of downstream reset domains (1..8); domain 0 is released first.
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high after entering PLL_RST (≥1).
- `LOCK_FILTER`, 1024: consecutive high samples of `pll_locked` required before release (≥1).
- `STAGE_DELAY`, 256: cycles between successive domain releases; also the soft-reset hold time (≥1).

- `clk`, in, 1: reference clock; every register in the block is on this clock.
- `rst`, in, 1: synchronous, active-high reset.
- `ext_rst_n`, in, 1: asynchronous active-low button reset; synchronised internally by 2 flops that reset to 1.
- `soft_rst`, in, 1: single-cycle soft-reset request; honoured only in RUN.
- `pll_locked`, in, 1: PLL lock indicator; treated as synchronous.
- `pll_rst`, out, 1: active-high PLL reset.
- `dom_rst_n`, out, NUM_DOMAINS: active-low per-domain resets; all registered.
- `sys_ready`, out, 1: high only in RUN.
- `lock_loss_cnt`, out, 8: saturating count of lock losses detected in RUN.

## Operation
- States: PLL_RST, WAIT_LOCK, FILTER, RELEASE, RUN, SOFT_HOLD. A counter and a domain index are shared across states.
- Reset values while `rst`=1:
  - state PLL_RST with counter cleared;
  - `pll_rst`=1, `dom_rst_n`=all 0, `sys_ready`=0;
  - `lock_loss_cnt`=0, sync flops=1.
- PLL_RST: `pll_rst`=1 and all domains are held in reset. After PLL_RST_CYCLES cycles the block goes to WAIT_LOCK and `pll_rst` goes to 0.
- WAIT_LOCK: when `pll_locked` is sampled 1, go to FILTER with the counter cleared.
- FILTER: count consecutive `pll_locked`=1 samples.
  - Any 0 sample returns the block to WAIT_LOCK. This does not count as a lock loss.
  - At LOCK_FILTER samples, go to RELEASE and set `dom_rst_n[0]`=1.
- RELEASE: every STAGE_DELAY cycles set the next `dom_rst_n[i]`=1. Released bits stay 1.
- End of RELEASE: one cycle after the last domain is released, go to RUN with `sys_ready`=1.
- Lock loss in RELEASE or RUN: `pll_locked`=0 →
  - go to PLL_RST;
  - all `dom_rst_n`=0 and `sys_ready`=0 on the next edge;
  - `lock_loss_cnt` increments, saturating at 255.
- SOFT_HOLD: `soft_rst`=1 in RUN → all `dom_rst_n`=0, `sys_ready`=0, `pll_rst` stays 0. Hold for STAGE_DELAY cycles, then re-enter RELEASE from domain 0. The PLL is not reset.
- SOFT_HOLD lock loss: `pll_locked`=0 here goes to PLL_RST and increments the counter.
- Synchronised `ext_rst_n`=0 in any state: go to PLL_RST and stay there (counter held at 0) while it stays low. `lock_loss_cnt` is preserved.
- Priority, highest first: `rst` > synchronised `ext_rst_n` > lock loss > `soft_rst`. A lock-loss increment is suppressed when an external reset coincides with it.
- `soft_rst` outside RUN is ignored and not queued.

## Timing
- Edge numbering: E0 is the first rising edge with `rst`=0. Values are register outputs after the stated edge. `pll_locked` is held high throughout unless stated otherwise.
- Bring-up sequence:
  - `pll_rst` falls at E(PLL_RST_CYCLES);
  - WAIT_LOCK→FILTER at E(PLL_RST_CYCLES+1);
  - `dom_rst_n[i]` rises at E(PLL_RST_CYCLES+1+LOCK_FILTER+i·STAGE_DELAY);
  - `sys_ready` rises one edge after the last domain rises.
- Lock loss: `pll_locked` sampled 0 at edge Ek → all `dom_rst_n`=0, `sys_ready`=0, `pll_rst`=1 and the counter incremented after Ek.
- External reset: `ext_rst_n` low, set up before edge Ek → all outputs at reset values after E(k+2). That is 2 sync flops plus the state register, ≤3 edges from the asynchronous edge.
- Soft reset: `soft_rst` at Ek → domains low after Ek. `dom_rst_n[0]` rises after E(k+2·STAGE_DELAY).

## Test plan
- Bring-up, NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_FILTER=8, STAGE_DELAY=5, locked always 1 → `pll_rst` falls at E4; `dom_rst_n` bits rise at E13, E18, E23; `sys_ready` rises at E24.
- Lock glitch during FILTER: locked=0 for 1 cycle at E9 → WAIT_LOCK entered; release restarts; `lock_loss_cnt` stays 0.
- Lock loss in RUN at E30 → after E30: `dom_rst_n`=000, `sys_ready`=0, `pll_rst`=1, `lock_loss_cnt`=1. Then 300 further losses → `lock_loss_cnt`=255.
- `soft_rst` pulse at E30 in RUN → domains low after E30; `pll_rst` stays 0; `dom_rst_n[0]` rises at E40, `[1]` at E45, `[2]` at E50; `sys_ready` rises at E51.
- `ext_rst_n` low for 20 cycles mid-RELEASE, coinciding with locked=0 → all domains low within 3 edges; `lock_loss_cnt` unchanged. After release, the full sequence restarts from PLL_RST.
- `rst` asserted mid-RUN → all outputs at reset values on the next edge and `lock_loss_cnt`=0; `soft_rst` pulsed in WAIT_LOCK → no effect.
